// File: rtl/lcd_nibble_tx.sv
// ============================================================================
// lcd_nibble_tx : HD44780 4-bit write engine (byte -> two E-framed nibbles).
// Optional power-up init sequence built when LCD_INIT_SEQ_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_nibble_tx #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned PULSE_CYCLES      = 4,
  parameter int unsigned HOLD_CYCLES       = 2,
  parameter int unsigned CMD_WAIT_CYCLES   = 400,
  parameter int unsigned CLEAR_WAIT_CYCLES = 16000,
  parameter int unsigned POWERUP_CYCLES    = 150000,
  parameter int unsigned INIT_WAIT_CYCLES  = 41000,
  parameter int unsigned CNT_W             = 18
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       RS,
  output logic       E,
  output logic       D4,
  output logic       D5,
  output logic       D6,
  output logic       D7
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    HI_SETUP = 4'd1,
    HI_PULSE = 4'd2,
    HI_HOLD  = 4'd3,
    LO_SETUP = 4'd4,
    LO_PULSE = 4'd5,
    LO_HOLD  = 4'd6,
    WAIT     = 4'd7
`ifdef LCD_INIT_SEQ_EN
    ,
    INIT_PWR = 4'd8,
    IN_SETUP = 4'd9,
    IN_PULSE = 4'd10,
    IN_HOLD  = 4'd11,
    IN_WAIT  = 4'd12
`endif
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam state_t RESET_STATE = INIT_PWR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nib;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             cnt_zero;
  logic             is_clear;

  assign cnt_zero = (cnt == '0);
  // Clear display / return home need the long settle time; 0x00 does not.
  assign is_clear = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  assign in_ready = (state == IDLE);
  assign D4 = nib[0];
  assign D5 = nib[1];
  assign D6 = nib[2];
  assign D7 = nib[3];

`ifdef LCD_INIT_SEQ_EN
  logic [1:0] step;
  logic       init_done_q;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RESET_STATE;
      cnt    <= '0;
      RS     <= 1'b0;
      E      <= 1'b0;
      nib    <= 4'h0;
      rs_q   <= 1'b0;
      byte_q <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      step        <= 2'd0;
      init_done_q <= 1'b0;
`endif
    end else begin
      if (state != IDLE && !cnt_zero
`ifdef LCD_INIT_SEQ_EN
          && state != INIT_PWR
`endif
         )
        cnt <= cnt - ONE;

      case (state)
        IDLE: if (in_valid) begin
          rs_q   <= in_rs;
          byte_q <= in_data;
          RS     <= in_rs;
          nib    <= in_data[7:4];
          cnt    <= SETUP_LD;
          state  <= HI_SETUP;
        end
        HI_SETUP: if (cnt_zero) begin
          E     <= 1'b1;
          cnt   <= PULSE_LD;
          state <= HI_PULSE;
        end
        HI_PULSE: if (cnt_zero) begin
          E     <= 1'b0;
          cnt   <= HOLD_LD;
          state <= HI_HOLD;
        end
        HI_HOLD: if (cnt_zero) begin
          nib   <= byte_q[3:0];
          cnt   <= SETUP_LD;
          state <= LO_SETUP;
        end
        LO_SETUP: if (cnt_zero) begin
          E     <= 1'b1;
          cnt   <= PULSE_LD;
          state <= LO_PULSE;
        end
        LO_PULSE: if (cnt_zero) begin
          E     <= 1'b0;
          cnt   <= HOLD_LD;
          state <= LO_HOLD;
        end
        LO_HOLD: if (cnt_zero) begin
          cnt   <= is_clear ? CLEAR_LD : CMD_LD;
          state <= WAIT;
        end
        WAIT: if (cnt_zero) state <= IDLE;
`ifdef LCD_INIT_SEQ_EN
        // Counts up from the reset value of 0 so the power-up wait needs no preload.
        INIT_PWR: begin
          if (cnt == PWR_LAST) begin
            nib   <= 4'h3;
            cnt   <= SETUP_LD;
            state <= IN_SETUP;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        IN_SETUP: if (cnt_zero) begin
          E     <= 1'b1;
          cnt   <= PULSE_LD;
          state <= IN_PULSE;
        end
        IN_PULSE: if (cnt_zero) begin
          E     <= 1'b0;
          cnt   <= HOLD_LD;
          state <= IN_HOLD;
        end
        IN_HOLD: if (cnt_zero) begin
          cnt   <= (step == 2'd0) ? INIT_LD : CMD_LD;
          state <= IN_WAIT;
        end
        IN_WAIT: if (cnt_zero) begin
          if (step == 2'd3) begin
            init_done_q <= 1'b1;
            state       <= IDLE;
          end else begin
            step  <= step + 2'd1;
            nib   <= (step == 2'd2) ? 4'h2 : 4'h3;
            cnt   <= SETUP_LD;
            state <= IN_SETUP;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
